audio_decimator: RTL and testbench
==================================

AUDIO_DECIMATOR -- requirements
Module: audio_decimator

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; every register SHALL update only on the rising edge of clk.
REQ-002 Parameter DECIM_LOG2, default 6: log2 of the number of input samples averaged per output sample.
REQ-003 Parameter SAMPLE_DIV, default 2000: number of clk cycles per output sample period; legal range is 4 or more, even.
REQ-004 Parameter MAX_CODE, default 16383: clamp ceiling for audio_sample; legal range is 1 to 16383.
REQ-005 Port clk, input, 1 bit: system clock.
REQ-006 Port RST, input, 1 bit: synchronous active-high reset.
REQ-007 Port enable, input, 1 bit: decimator enable; when low, accumulation is held cleared.
REQ-008 Port in_valid, input, 1 bit: in_data is qualified on any cycle where this is high.
REQ-009 Port in_data, input, 16 bits: signed two's-complement demodulated sample.
REQ-010 Port sample_clk, output, 1 bit: output sample-rate square wave.
REQ-011 Port sample_stb, output, 1 bit: one-cycle pulse coincident with each rising edge of sample_clk.
REQ-012 Port audio_sample, output, 14 bits: unsigned sample code for the PWM stage.
REQ-013 Port pending, output, 1 bit: a converted sample is waiting for the next tick.
REQ-014 Port overrun, output, 1 bit: sticky flag set when a pending sample is overwritten.

Function
REQ-015 Accumulator: signed, 16+DECIM_LOG2 bits wide, with a sample counter 0..2^DECIM_LOG2-1; each qualified sample (enable=1, in_valid=1) SHALL be sign-extended, added to the accumulator, and increment the counter.
REQ-016 The qualified sample that arrives when the counter equals 2^DECIM_LOG2-1 SHALL be included in the sum, then:
- avg = (acc + in_data) arithmetically shifted right by DECIM_LOG2;
- the accumulator and counter SHALL clear to 0 in the same cycle.
REQ-017 Conversion stage, registered, 1 cycle:
- u = avg + 32768, a 16-bit unsigned value;
- code = u >> 2;
- code SHALL be clamped to min(code, MAX_CODE);
- the result SHALL load the pending register, and pending SHALL go to 1 on the clock edge after the final input sample.
REQ-018 Divider: counter div runs 0..SAMPLE_DIV-1 and wraps; let div_next be the next value of div. The following SHALL be registered each cycle:
- sample_clk <= (div_next < SAMPLE_DIV/2);
- sample_stb <= (div_next == 0).
REQ-019 The divider SHALL run regardless of enable and of in_valid.
REQ-020 Tick, on the edge where sample_stb becomes 1:
- if pending=1, audio_sample SHALL take the pending value and pending SHALL clear;
- otherwise audio_sample SHALL hold its previous value.
REQ-021 If a conversion completes on the same edge as a tick:
- the tick SHALL take the old pending value, if one exists, else hold;
- the new value SHALL go into the pending register with pending=1;
- overrun SHALL NOT be set.
REQ-022 If a conversion completes while pending=1 and no tick occurs on that edge, the pending value SHALL be overwritten with the new value and overrun SHALL set to 1.
REQ-023 overrun SHALL clear only on RST.
REQ-024 enable=0 SHALL clear the accumulator, the counter, the conversion stage and pending on the next edge; audio_sample, the divider and overrun SHALL be unaffected.
REQ-025 If enable falls while a conversion is in flight, that conversion SHALL be discarded.
REQ-026 in_valid may be asserted on any cycle, including back-to-back every cycle; no sample SHALL be dropped while enable=1.

Reset
REQ-027 On RST=1 the following SHALL be set to 0: accumulator, counter, conversion stage, div, pending, sample_clk, sample_stb, audio_sample and overrun.
REQ-028 A reset asserted mid-accumulation SHALL discard partial sums.
REQ-029 After RST is released, the first sample_stb SHALL occur on the SAMPLE_DIV-th rising edge of clk.
REQ-030 RST SHALL take priority over every other input.

Verification
All scenarios use DECIM_LOG2=2 and SAMPLE_DIV=8 unless stated.
REQ-031 Four back-to-back samples of 0x0000 -> pending=1 one cycle after the 4th sample; at the next sample_stb, audio_sample=8192 and pending=0.
REQ-032 With MAX_CODE=10000: four samples of 0x7FFF -> audio_sample=10000 (clamped); then four samples of 0x8000 -> audio_sample=0.
REQ-033 Samples -1, -1, -1, -2 (sum -5, avg -2, u=32766) -> audio_sample=8191, which confirms the arithmetic shift on a negative sum.
REQ-034 With SAMPLE_DIV=64: two complete averages between ticks (values 8192 then 0) -> overrun=1, the next tick yields audio_sample=0, and overrun stays 1 until RST.
REQ-035 With the final sample timed so that the conversion completes on a tick edge, old pending value 8192 and new value 0 -> audio_sample=8192 at that tick, pending=1, overrun=0, and audio_sample=0 at the following tick.
REQ-036 RST pulse after 2 of 4 samples, then four samples of 0x7FFF -> audio_sample=16383 (MAX_CODE default) with no contribution from pre-reset samples; sample_clk pattern is high for 4 cycles, low for 4 cycles; sample_stb occurs every 8 cycles.

Source files
------------

// File: rtl/audio_decimator.sv
// Block-average decimator for demodulated audio: sums 2^DECIM_LOG2 signed samples,
// converts the average to an unsigned 14-bit code and releases it on each sample tick.
module audio_decimator #(
    parameter int DECIM_LOG2 = 6,
    parameter int SAMPLE_DIV = 2000,
    parameter int MAX_CODE   = 16383
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        sample_clk,
    output logic        sample_stb,
    output logic [13:0] audio_sample,
    output logic        pending,
    output logic        overrun
);

    localparam int ACCW = 16 + DECIM_LOG2;
    localparam int DIVW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SAMPLE_DIV - 1);
    localparam logic [DIVW-1:0] DIV_HALF = DIVW'(SAMPLE_DIV / 2);
    localparam logic [13:0]     CODE_MAX = 14'(MAX_CODE);

    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] in_ext;
    logic signed [ACCW-1:0] sum;
    logic [DECIM_LOG2-1:0]  cnt;
    logic                   qualified;
    logic                   last_sample;

    logic                   conv_valid;
    logic [13:0]            avg_hi;
    logic [13:0]            code;
    logic [13:0]            code_clamped;
    logic [13:0]            pend_val;

    logic [DIVW-1:0]        div;
    logic [DIVW-1:0]        div_next;
    logic                   tick;

    // The conversion stage keeps only avg[15:2]; flipping its MSB equals (avg + 32768) >> 2.
    always_comb begin
        in_ext       = {{DECIM_LOG2{in_data[15]}}, in_data};
        sum          = acc + in_ext;
        qualified    = enable && in_valid;
        last_sample  = qualified && (cnt == '1);
        code         = {~avg_hi[13], avg_hi[12:0]};
        code_clamped = (code > CODE_MAX) ? CODE_MAX : code;
        div_next     = (div == DIV_LAST) ? '0 : div + DIVW'(1);
        tick         = (div_next == '0);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            acc          <= '0;
            cnt          <= '0;
            conv_valid   <= 1'b0;
            avg_hi       <= '0;
            pend_val     <= '0;
            pending      <= 1'b0;
            div          <= '0;
            sample_clk   <= 1'b0;
            sample_stb   <= 1'b0;
            audio_sample <= '0;
            overrun      <= 1'b0;
        end else begin
            div        <= div_next;
            sample_clk <= (div_next < DIV_HALF);
            sample_stb <= tick;

            if (tick && pending)
                audio_sample <= pend_val;

            if (!enable) begin
                acc        <= '0;
                cnt        <= '0;
                conv_valid <= 1'b0;
                avg_hi     <= '0;
                pending    <= 1'b0;
            end else begin
                conv_valid <= last_sample;
                if (qualified) begin
                    if (last_sample) begin
                        avg_hi <= 14'(sum >>> (DECIM_LOG2 + 2));
                        acc    <= '0;
                        cnt    <= '0;
                    end else begin
                        acc <= sum;
                        cnt <= cnt + DECIM_LOG2'(1);
                    end
                end

                // A tick on the same edge already consumes the old value, so no overrun then.
                if (conv_valid) begin
                    pend_val <= code_clamped;
                    pending  <= 1'b1;
                    if (pending && !tick)
                        overrun <= 1'b1;
                end else if (tick) begin
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_audio_decimator.sv
// Directed bench for audio_decimator: three instances (default clamp, MAX_CODE=10000,
// SAMPLE_DIV=64) share clock, reset and sample inputs; each has its own enable.
module tb_audio_decimator;

    logic        clk;
    logic        RST;
    logic        in_valid;
    logic [15:0] in_data;
    logic        en0, en1, en2;

    logic        sclk0, stb0, pend0, ovr0;
    logic        sclk1, stb1, pend1, ovr1;
    logic        sclk2, stb2, pend2, ovr2;
    logic [13:0] as0, as1, as2;

    int checks = 0;
    int errors = 0;

    audio_decimator #(.DECIM_LOG2(2), .SAMPLE_DIV(8)) u0 (
        .clk(clk), .RST(RST), .enable(en0), .in_valid(in_valid), .in_data(in_data),
        .sample_clk(sclk0), .sample_stb(stb0), .audio_sample(as0),
        .pending(pend0), .overrun(ovr0)
    );

    audio_decimator #(.DECIM_LOG2(2), .SAMPLE_DIV(8), .MAX_CODE(10000)) u1 (
        .clk(clk), .RST(RST), .enable(en1), .in_valid(in_valid), .in_data(in_data),
        .sample_clk(sclk1), .sample_stb(stb1), .audio_sample(as1),
        .pending(pend1), .overrun(ovr1)
    );

    audio_decimator #(.DECIM_LOG2(2), .SAMPLE_DIV(64)) u2 (
        .clk(clk), .RST(RST), .enable(en2), .in_valid(in_valid), .in_data(in_data),
        .sample_clk(sclk2), .sample_stb(stb2), .audio_sample(as2),
        .pending(pend2), .overrun(ovr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] v);
        in_valid = 1'b1;
        in_data  = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_stb(input int which, output int n);
        logic s;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            case (which)
                0:       s = stb0;
                1:       s = stb1;
                default: s = stb2;
            endcase
        end while (!s && n < 200);
        check("stb_within_bound", 32'(n < 200), 32'd1);
    endtask

    initial begin
        int n;
        RST      = 1'b1;
        en0      = 1'b0;
        en1      = 1'b0;
        en2      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_audio", 32'(as0), 32'd0);
        check("rst_pending", 32'(pend0), 32'd0);
        check("rst_overrun", 32'(ovr0), 32'd0);
        check("rst_sclk", 32'(sclk0), 32'd0);
        check("rst_stb", 32'(stb0), 32'd0);
        RST = 1'b0;

        // Divider: high 4 / low 4, strobe on the 8th edge after reset release
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("sclk_edge%0d", i), 32'(sclk0), 32'((i % 8) < 4));
            check($sformatf("stb_edge%0d", i), 32'(stb0), 32'((i % 8) == 0));
        end

        // Four zeros -> 8192
        en0 = 1'b1;
        repeat (4) push(16'h0000);
        check("zero_pend_in_flight", 32'(pend0), 32'd0);
        @(posedge clk);
        #1;
        check("zero_pend_set", 32'(pend0), 32'd1);
        wait_stb(0, n);
        check("zero_audio", 32'(as0), 32'd8192);
        check("zero_pend_clr", 32'(pend0), 32'd0);

        // -1,-1,-1,-2 -> avg -2 -> 8191
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'hFFFF);
        push(16'hFFFE);
        wait_stb(0, n);
        check("neg_shift_audio", 32'(as0), 32'd8191);

        // Clamp to MAX_CODE=10000, then full negative -> 0
        en0 = 1'b0;
        en1 = 1'b1;
        repeat (4) push(16'h7FFF);
        wait_stb(1, n);
        check("clamp_audio", 32'(as1), 32'd10000);
        repeat (4) push(16'h8000);
        wait_stb(1, n);
        check("minneg_audio", 32'(as1), 32'd0);
        check("disabled_hold_audio", 32'(as0), 32'd8191);
        check("disabled_pend", 32'(pend0), 32'd0);

        // Conversion completing on a tick edge: old 8192 delivered, new 0 stays pending
        en1 = 1'b0;
        en0 = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        repeat (4) push(16'h0000);
        repeat (4) push(16'h8000);
        check("coinc_pend_before", 32'(pend0), 32'd1);
        check("coinc_ovr_before", 32'(ovr0), 32'd0);
        @(posedge clk);
        #1;
        check("coinc_stb", 32'(stb0), 32'd1);
        check("coinc_audio_old", 32'(as0), 32'd8192);
        check("coinc_pend_new", 32'(pend0), 32'd1);
        check("coinc_no_overrun", 32'(ovr0), 32'd0);
        wait_stb(0, n);
        check("coinc_audio_new", 32'(as0), 32'd0);
        check("coinc_pend_clr", 32'(pend0), 32'd0);

        // Overrun with SAMPLE_DIV=64: 8192 then 0 before the tick
        en0 = 1'b0;
        en2 = 1'b1;
        repeat (4) push(16'h0000);
        repeat (4) push(16'h8000);
        check("ovr_pend_first", 32'(pend2), 32'd1);
        check("ovr_not_yet", 32'(ovr2), 32'd0);
        @(posedge clk);
        #1;
        check("ovr_set", 32'(ovr2), 32'd1);
        check("ovr_pend", 32'(pend2), 32'd1);
        wait_stb(2, n);
        check("ovr_audio", 32'(as2), 32'd0);
        check("ovr_pend_clr", 32'(pend2), 32'd0);
        check("ovr_sticky", 32'(ovr2), 32'd1);

        // Enable dropped while a conversion is in flight: result discarded
        en2 = 1'b0;
        en0 = 1'b1;
        repeat (4) push(16'h0000);
        en0 = 1'b0;
        @(posedge clk);
        #1;
        check("discard_pend", 32'(pend0), 32'd0);
        wait_stb(0, n);
        check("discard_audio", 32'(as0), 32'd0);
        check("discard_ovr_sticky", 32'(ovr2), 32'd1);

        // Reset after two samples, then four 0x7FFF -> 16383
        en0 = 1'b1;
        push(16'h8000);
        push(16'h8000);
        RST = 1'b1;
        @(posedge clk);
        #1;
        RST = 1'b0;
        check("midrst_pend", 32'(pend0), 32'd0);
        check("midrst_sclk", 32'(sclk0), 32'd0);
        check("midrst_stb", 32'(stb0), 32'd0);
        check("midrst_ovr_clr", 32'(ovr2), 32'd0);
        repeat (4) push(16'h7FFF);
        check("midrst_no_stale", 32'(pend0), 32'd0);
        wait_stb(0, n);
        check("midrst_first_stb", 32'(n), 32'd4);
        check("midrst_audio", 32'(as0), 32'd16383);
        check("midrst_pend_clr", 32'(pend0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
